// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch front end: 64-byte line fill from the bus, 32-bit instructions to decode
//
// Purpose:
//   Issues one line-aligned read per cache line and collects LINE_BEATS
//   64-bit response beats into a local line buffer. It then presents the
//   32-bit instructions of that line, with their PCs, to decode over a
//   valid/ready handshake. A redirect always causes a fresh line fetch,
//   even when the target lies in the line already buffered.
//
// Ports:
//   clk            - clock; all state updates happen on its rising edge
//   reset          - asynchronous active-low reset
//   entry          - program entry PC, loaded into pc while reset is low
//   bus_reqcyc     - read request valid (registered)
//   bus_req        - line-aligned request address (registered)
//   bus_reqtag     - request tag, FETCH_TAG while a request is pending
//   bus_reqack     - bus accepted the pending request
//   bus_respcyc    - response beat valid
//   bus_resp       - response beat data
//   bus_resptag    - response tag (ignored)
//   bus_respack    - response beat consumed (combinational in RESP)
//   inst_valid     - instruction available to decode
//   inst           - instruction word
//   inst_pc        - PC of inst
//   inst_ready     - decode accepts inst
//   redirect_valid - single-cycle redirect pulse
//   redirect_pc    - new fetch PC

module fetch_unit #(
    parameter int                        BUS_DATA_WIDTH = 64,
    parameter int                        BUS_TAG_WIDTH  = 13,
    parameter logic [BUS_TAG_WIDTH-1:0]  FETCH_TAG      = 13'h1100,
    parameter int                        LINE_BEATS     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BUS_DATA_WIDTH-1:0] entry,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,

    output logic                      inst_valid,
    output logic [31:0]               inst,
    output logic [BUS_DATA_WIDTH-1:0] inst_pc,
    input  logic                      inst_ready,

    input  logic                      redirect_valid,
    input  logic [BUS_DATA_WIDTH-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        flush_q, flush_d;
    logic                        reqcyc_q, reqcyc_d;
    logic [BUS_DATA_WIDTH-1:0]   req_q, req_d;
    logic [BUS_TAG_WIDTH-1:0]    reqtag_q, reqtag_d;

    logic [BUS_DATA_WIDTH-1:0]   buf_q [LINE_BEATS];

    logic                        go_req;
    logic                        buf_we;
    logic                        handshake;
    logic [BUS_DATA_WIDTH-1:0]   redirect_target;
    logic [BUS_DATA_WIDTH-1:0]   cur_beat;

    // Response tag and the low two redirect bits carry no information here.
    logic                        unused_inputs;
    assign unused_inputs = ^{bus_resptag, redirect_pc[1:0]};

    assign redirect_target = {redirect_pc[BUS_DATA_WIDTH-1:2], 2'b00};
    assign handshake       = (state_q == S_DRAIN) && inst_ready;

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        flush_d  = flush_q;
        reqcyc_d = reqcyc_q;
        req_d    = req_q;
        reqtag_d = reqtag_q;
        go_req   = 1'b0;
        buf_we   = 1'b0;

        // A redirect always lands in pc, whatever the state; in DRAIN it
        // also overrides the pc+4 of a simultaneous handshake.
        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (handshake) begin
            pc_d = pc_q + BUS_DATA_WIDTH'(4);
        end

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                go_req  = 1'b1;
            end

            S_REQ: begin
                // The request already on the bus is left untouched; the
                // line it returns is thrown away after it has fully arrived.
                if (redirect_valid) begin
                    flush_d = 1'b1;
                end
                if (bus_reqack) begin
                    state_d  = S_RESP;
                    cnt_d    = '0;
                    reqcyc_d = 1'b0;
                    req_d    = '0;
                    reqtag_d = '0;
                end
            end

            S_RESP: begin
                if (redirect_valid) begin
                    flush_d = 1'b1;
                end
                if (bus_respcyc) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        // A redirect arriving with the final beat must also
                        // discard the line, so it is folded in here.
                        if (flush_q || redirect_valid) begin
                            flush_d = 1'b0;
                            state_d = S_REQ;
                            go_req  = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end

            S_DRAIN: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                    go_req  = 1'b1;
                end else if (handshake && (pc_q[5:2] == 4'hF)) begin
                    state_d = S_REQ;
                    go_req  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The request address is taken from the pc the next cycle will
        // hold, so a redirect or line crossing on this edge is honoured.
        if (go_req) begin
            reqcyc_d = 1'b1;
            req_d    = {pc_d[BUS_DATA_WIDTH-1:6], 6'b000000};
            reqtag_d = FETCH_TAG;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= entry;
            cnt_q    <= '0;
            flush_q  <= 1'b0;
            reqcyc_q <= 1'b0;
            req_q    <= '0;
            reqtag_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            reqcyc_q <= reqcyc_d;
            req_q    <= req_d;
            reqtag_q <= reqtag_d;
        end
    end

    // Line buffer holds data only; its contents are never consumed before
    // a full line has been written, so it needs no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[cnt_q] <= bus_resp;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cur_beat    = buf_q[pc_q[5:3]];

    assign bus_reqcyc  = reqcyc_q;
    assign bus_req     = req_q;
    assign bus_reqtag  = reqtag_q;
    assign bus_respack = (state_q == S_RESP) && bus_respcyc;

    assign inst_valid  = (state_q == S_DRAIN);
    assign inst_pc     = inst_valid ? pc_q : '0;
    assign inst        = !inst_valid ? 32'h0 :
                         (pc_q[2] ? cur_beat[63:32] : cur_beat[31:0]);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a PC-stream reference model

module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [63:0] entry;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .bus_reqcyc     (bus_reqcyc),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_reqack     (bus_reqack),
        .bus_respcyc    (bus_respcyc),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag),
        .bus_respack    (bus_respack),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the PC decode must see next, plus a bus responder.
    logic [63:0] model_pc;
    int          rsp_phase;      // 0 no request, 1 request seen, 2 returning beats
    int          ack_delay;
    logic [63:0] line_addr;
    int          beats_sent;
    bit          just_acked;
    bit          prev_valid, prev_ready, prev_redirect;
    logic [63:0] prev_pc;
    logic [31:0] prev_inst;
    int          handshakes;

    // Memory contents: a distinct word for every word address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] w;
        w = a[33:2] * 32'h9E37_79B1;
        return w ^ {2'b00, a[63:34]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pick_target();
        case ($urandom_range(0, 2))
            0:       return 64'h2000 + 64'($urandom_range(0, 255));
            1:       return {model_pc[63:6], 6'b0} + 64'($urandom_range(0, 63));
            default: return 64'hFFFF_FFFF_FFFF_FFC0 + 64'($urandom_range(0, 63));
        endcase
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit allow_redirect);
        bit hs, rd, ack, beat;
        int phase_now;

        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = 13'($urandom);

        if (just_acked) check("req_drop", 64'(bus_reqcyc), 64'd0);

        if (rsp_phase == 0 && bus_reqcyc) begin
            rsp_phase = 1;
            line_addr = bus_req;
            ack_delay = $urandom_range(0, 3);
            check("req_tag", 64'(bus_reqtag), 64'h1100);
            check("req_align", 64'(bus_req[5:0]), 64'd0);
        end
        if (rsp_phase == 1) begin
            check("req_stable", bus_req, line_addr);
            check("req_held", 64'(bus_reqcyc), 64'd1);
            if (ack_delay == 0) bus_reqack = 1'b1;
            else ack_delay--;
        end else if (rsp_phase == 2) begin
            check("no_req_in_resp", 64'(bus_reqcyc), 64'd0);
            if ($urandom_range(0, 2) != 0) begin
                bus_respcyc = 1'b1;
                bus_resp = {mem_word(line_addr + 64'(8 * beats_sent + 4)),
                            mem_word(line_addr + 64'(8 * beats_sent))};
            end
        end

        inst_ready = ($urandom_range(0, 9) < 7);
        if (allow_redirect && $urandom_range(0, 29) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = pick_target();
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = {$urandom, $urandom};
        end
        #1;

        check("respack", 64'(bus_respack), 64'((rsp_phase == 2) && bus_respcyc));

        if (prev_redirect) begin
            check("redirect_kill", 64'(inst_valid), 64'd0);
        end else if (prev_valid && !prev_ready) begin
            check("stall_valid", 64'(inst_valid), 64'd1);
            check("stall_pc", inst_pc, prev_pc);
            check("stall_inst", 64'(inst), 64'(prev_inst));
        end
        if (inst_valid) begin
            check("inst_pc", inst_pc, model_pc);
            check("inst", 64'(inst), 64'(mem_word(model_pc)));
        end

        hs        = inst_valid && inst_ready;
        rd        = redirect_valid;
        phase_now = rsp_phase;
        ack       = (phase_now == 1) && bus_reqack;
        beat      = (phase_now == 2) && bus_respcyc;
        prev_valid    = inst_valid;
        prev_ready    = inst_ready;
        prev_redirect = rd;
        prev_pc       = inst_pc;
        prev_inst     = inst;

        @(posedge clk);
        if (hs) handshakes++;
        if (rd) model_pc = {redirect_pc[63:2], 2'b00};
        else if (hs) model_pc = model_pc + 64'd4;
        just_acked = ack;
        if (ack) begin
            rsp_phase  = 2;
            beats_sent = 0;
        end else if (beat) begin
            beats_sent++;
            if (beats_sent == 8) rsp_phase = 0;
        end
        @(negedge clk);
    endtask

    // Entered at a falling edge; asserts reset between edges and releases it.
    task automatic reset_dut(input logic [63:0] e);
        #2;
        reset = 1'b0;
        entry = e;
        #1;
        check("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        check("rst_req", bus_req, 64'd0);
        check("rst_reqtag", 64'(bus_reqtag), 64'd0);
        check("rst_respack", 64'(bus_respack), 64'd0);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);

        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        rsp_phase = 0; just_acked = 0; model_pc = e;
        prev_valid = 0; prev_ready = 0; prev_redirect = 0;

        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("idle_reqcyc", 64'(bus_reqcyc), 64'd0);
        @(negedge clk);
        check("first_reqcyc", 64'(bus_reqcyc), 64'd1);
        check("first_req", bus_req, {e[63:6], 6'b0});
        check("first_tag", 64'(bus_reqtag), 64'h1100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_reqcyc", 64'(bus_reqcyc), 64'd1);
            check("hold_req", bus_req, {e[63:6], 6'b0});
        end
    endtask

    initial begin
        int guard;
        int hs_before;

        reset = 1'b1; entry = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        handshakes = 0; rsp_phase = 0; just_acked = 0; beats_sent = 0;
        ack_delay = 0; line_addr = '0; model_pc = '0;
        prev_valid = 0; prev_ready = 0; prev_redirect = 0; prev_pc = '0; prev_inst = '0;

        @(negedge clk);
        reset_dut(64'h1000);
        repeat (1500) cycle(1'b1);

        // Reset in the middle of a line fill, after a few beats have arrived.
        guard = 0;
        while (!(rsp_phase == 2 && beats_sent >= 3) && guard < 2000) begin
            cycle(1'b1);
            guard++;
        end
        check("mid_resp_reached", 64'(guard < 2000), 64'd1);
        reset_dut(64'h1038);
        repeat (1500) cycle(1'b1);

        // Sequential fetch across the top of the address space.
        reset_dut(64'hFFFF_FFFF_FFFF_FFF0);
        hs_before = handshakes;
        repeat (400) cycle(1'b0);
        check("pc_wrapped", 64'(model_pc < 64'h1000), 64'd1);
        check("wrap_progress", 64'(handshakes - hs_before > 20), 64'd1);
        check("progress", 64'(handshakes > 300), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end that sits between the Sysbus and the decode stage. It issues 64-byte line read requests, collects 8 response beats into a line buffer, and hands 32-bit instructions with their PCs to decode over a valid/ready interface. It supports a redirect input for branches and jumps.

Parameters:
BUS_DATA_WIDTH, 64, bus data/address width; only 64 is supported.
BUS_TAG_WIDTH, 13, bus tag width.
FETCH_TAG, 13'h1100, tag driven on bus_reqtag for every line read (memory read).
LINE_BEATS, 8, response beats per line (64 bytes).

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
entry  in  64  program entry PC, sampled while reset is asserted
bus_reqcyc  out  1  read request valid
bus_req  out  64  line-aligned request address
bus_reqtag  out  13  request tag
bus_reqack  in  1  bus accepted the request
bus_respcyc  in  1  response beat valid
bus_resp  in  64  response beat data
bus_resptag  in  13  response tag (not checked)
bus_respack  out  1  response beat consumed
inst_valid  out  1  instruction available to decode
inst  out  32  instruction word
inst_pc  out  64  PC of inst
inst_ready  in  1  decode accepts inst
redirect_valid  in  1  redirect request, single-cycle pulse
redirect_pc  in  64  new fetch PC

Behaviour:
- Reset (reset==0, takes effect immediately):
  - state=IDLE, pc=entry, beat counter=0, flush_pending=0.
  - All bus outputs, inst_valid, inst and inst_pc are 0.
- States: IDLE, REQ, RESP, DRAIN.
- IDLE: after reset is released, moves to REQ on the next clk edge.
- REQ:
  - bus_reqcyc=1, bus_req={pc[63:6],6'b0}, bus_reqtag=FETCH_TAG.
  - Outputs are registered and held stable until bus_reqack is sampled 1.
  - On that edge: reqcyc/req/reqtag drop to 0, beat counter clears to 0, state moves to RESP.
- RESP:
  - bus_respack = bus_respcyc, combinationally, in the same cycle.
  - Each cycle with respcyc==1: buf[cnt] <= bus_resp, cnt++.
  - Gaps in respcyc are allowed. Beats are never dropped.
  - After beat 7 is stored: if flush_pending, clear it and go to REQ; otherwise go to DRAIN.
- DRAIN:
  - inst_valid=1, inst_pc=pc.
  - inst = buf[pc[5:3]][31:0] when pc[2]==0, else buf[pc[5:3]][63:32].
  - On inst_valid&inst_ready: pc<=pc+4.
  - If pc[5:2]==15 at that handshake, go to REQ (next line). Otherwise stay in DRAIN.
  - inst and inst_pc must stay stable while inst_ready==0.
- Redirect:
  - pc always takes {redirect_pc[63:2],2'b00} on the edge where redirect_valid==1.
  - In DRAIN: go to REQ; inst_valid is 0 from the next cycle. A simultaneous inst handshake counts as accepted, but redirect_pc wins over pc+4.
  - In REQ: the outstanding request is not altered; set flush_pending. bus_req keeps the old address until reqack.
  - In RESP: set flush_pending and keep acking and storing the remaining beats.
  - In IDLE: pc update only.
- No line reuse: every redirect refetches, even into the same line.
- Entry or redirect mid-line: request the aligned line; delivery starts at pc[5:2].
- pc+4 arithmetic is 64-bit and wraps modulo 2^64.

Test Plan:
1. entry=0x1000, release reset -> IDLE for one cycle, then bus_reqcyc=1, bus_req=0x1000, bus_reqtag=0x1100. Hold ack low 3 cycles -> request stable. Ack -> bus_reqcyc=0 next cycle.
2. Return 8 beats, beat k = {32'(2k+1),32'(2k)}, inst_ready=1 -> 16 instructions 0..15 with inst_pc 0x1000..0x103C, bus_respack high with each beat. Then request 0x1040.
3. entry=0x1038 -> request 0x1000, exactly two instructions (pc 0x1038 and 0x103C, values 14 and 15), then request 0x1040.
4. In DRAIN, hold inst_ready=0 for 5 cycles -> inst_valid=1 and inst/inst_pc unchanged. Release -> pc advances by 4 per cycle.
5. Pulse redirect_pc=0x2006 after beat 3 of RESP, with respcyc gapped -> beats 4..7 still acked, inst_valid stays 0. Next request is 0x2000; first inst_pc=0x2004 with buf[0][63:32].
6. Assert reset mid-RESP (after beat 2) -> all outputs 0 immediately without a clock. On release, refetch from entry with the beat counter restarting at 0.
7. Redirect and handshake in the same DRAIN cycle -> next request address comes from redirect_pc, not pc+4.
